// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode decode and default word size, shared by the SPI master and slave
package spi_pkg;
  localparam int DEFAULT_DATAWIDTH = 8;
  typedef enum logic {IDLE, SELECTED} spi_slave_state_t;
  function automatic logic cpol(input int mode);
    return mode[1];
  endfunction
  function automatic logic cpha(input int mode);
    return mode[0];
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer plus history flop, with rise/fall detect on the synchronized value
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic meta, hist;
  always_ff @(posedge i_clk)
    if (!i_reset_n) {meta, o_sync, hist} <= {3{RESET_VAL}};
    else {meta, o_sync, hist} <= {i_async, meta, o_sync};
  assign o_rise = o_sync & ~hist;
  assign o_fall = ~o_sync & hist;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI peripheral endpoint, MSB first, any SPI mode, with a one-word TX holding register
module spi_slave import spi_pkg::*; #(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int SPI_MODE = 0,
  parameter logic [DATAWIDTH-1:0] DEFAULT_TX = {DATAWIDTH{1'b1}}
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [DATAWIDTH-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_underrun,
  output logic [DATAWIDTH-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_spi_clk,
  input  logic                 i_spi_cs_n,
  input  logic                 i_spi_MOSI,
  output logic                 o_spi_MISO,
  output logic                 o_spi_MISO_en
);
  localparam int CW = $clog2(DATAWIDTH);
  localparam logic CPOL = cpol(SPI_MODE);
  localparam logic CPHA = cpha(SPI_MODE);
  logic sck_sync, sck_rise, sck_fall, cs_sync, cs_rise, cs_fall, mosi, mosi_rise, mosi_fall;
  logic unused_sync;
  logic lead, trail, sample, shift_edge, load, wr, hold_full, fresh;
  logic [DATAWIDTH-1:0] hold, tx_sr, tx_word, rx_next;
  logic [DATAWIDTH-2:0] rx_sr;
  logic [CW-1:0] bit_cnt;
  spi_slave_state_t state;
  spi_sync_edge #(.RESET_VAL(CPOL)) u_sck (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_spi_clk),
    .o_sync(sck_sync), .o_rise(sck_rise), .o_fall(sck_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_spi_cs_n),
    .o_sync(cs_sync), .o_rise(cs_rise), .o_fall(cs_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async(i_spi_MOSI),
    .o_sync(mosi), .o_rise(mosi_rise), .o_fall(mosi_fall)
  );
  assign unused_sync = ^{sck_sync, cs_sync, mosi_rise, mosi_fall};
  assign lead = CPOL ? sck_fall : sck_rise;
  assign trail = CPOL ? sck_rise : sck_fall;
  assign sample = CPHA ? trail : lead;
  assign shift_edge = CPHA ? lead : trail;
  assign tx_word = hold_full ? hold : DEFAULT_TX;
  assign rx_next = {rx_sr, mosi};
  assign o_tx_ready = ~hold_full;
  assign wr = i_tx_valid & ~hold_full;
  // a shift edge with the counter at zero starts a new word; with CPHA=1 the first one after CS fall was already loaded
  assign load = (state == IDLE) ? cs_fall : ~cs_rise & shift_edge & (bit_cnt == '0) & ~fresh;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      fresh <= 1'b0;
      o_rx_data <= '0;
      o_rx_valid <= 1'b0;
      o_tx_underrun <= 1'b0;
      o_spi_MISO <= 1'b0;
      o_spi_MISO_en <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_tx_underrun <= load & ~hold_full;
      if (wr) hold <= i_tx_data;
      hold_full <= wr | (hold_full & ~load);
      if (load) begin
        tx_sr <= tx_word;
        o_spi_MISO <= tx_word[DATAWIDTH-1];
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (cs_fall) begin
          state <= SELECTED;
          o_spi_MISO_en <= 1'b1;
          fresh <= CPHA;
        end
      end else if (cs_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
        o_spi_MISO_en <= 1'b0;
      end else begin
        if (sample) begin
          rx_sr <= rx_next[DATAWIDTH-2:0];
          bit_cnt <= (bit_cnt == CW'(DATAWIDTH-1)) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATAWIDTH-1)) begin
            o_rx_data <= rx_next;
            o_rx_valid <= 1'b1;
          end
        end
        if (shift_edge && bit_cnt != '0) begin
          tx_sr <= tx_sr << 1;
          o_spi_MISO <= tx_sr[DATAWIDTH-2];
        end
        if (shift_edge) fresh <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench driving one spi_slave per SPI mode through a bit-banged master
module tb_spi_slave;
  localparam int H = 6;
  typedef struct {
    int mode;
    logic has_tx;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int exp_und;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sck = 4'b1100;
  logic [3:0] cs_n = 4'b1111;
  logic [3:0] mosi = 4'b0000;
  logic [3:0] tx_valid = 4'b0000;
  logic [3:0] tx_ready, underrun, rx_valid, miso, miso_en;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];
  logic [7:0] rx_hist [4][64];
  int rx_cnt [4] = '{default: 0};
  int und_cnt [4] = '{default: 0};
  int n_tests = 0;
  int n_fail = 0;
  vec_t vecs [5];
  always #5 clk = ~clk;
  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave #(.SPI_MODE(m)) u_dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
      .i_tx_data(tx_data[m]),
      .i_tx_valid(tx_valid[m]),
      .o_tx_ready(tx_ready[m]),
      .o_tx_underrun(underrun[m]),
      .o_rx_data(rx_data[m]),
      .o_rx_valid(rx_valid[m]),
      .i_spi_clk(sck[m]),
      .i_spi_cs_n(cs_n[m]),
      .i_spi_MOSI(mosi[m]),
      .o_spi_MISO(miso[m]),
      .o_spi_MISO_en(miso_en[m])
    );
  end
  always @(negedge clk)
    for (int m = 0; m < 4; m++) begin
      if (rx_valid[m]) begin
        rx_hist[m][rx_cnt[m] % 64] <= rx_data[m];
        rx_cnt[m] <= rx_cnt[m] + 1;
      end
      if (underrun[m]) und_cnt[m] <= und_cnt[m] + 1;
    end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    cs_n = 4'b1111;
    sck = 4'b1100;
    tx_valid = 4'b0000;
    tick(4);
    rst_n = 1'b1;
    tick(2);
  endtask
  task automatic load_tx(int m, logic [7:0] d);
    int c = 0;
    while (tx_ready[m] !== 1'b1 && c < 2000) begin
      tick(1);
      c++;
    end
    check($sformatf("tx_ready wait m%0d", m), {31'b0, tx_ready[m]}, 1);
    tx_data[m] = d;
    tx_valid[m] = 1'b1;
    tick(1);
    tx_valid[m] = 1'b0;
  endtask
  task automatic cs_low(int m);
    cs_n[m] = 1'b0;
    tick(H);
  endtask
  task automatic cs_high(int m);
    tick(H);
    cs_n[m] = 1'b1;
    tick(H);
  endtask
  task automatic xfer(int m, logic [7:0] mo, int nbits, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = 1'((m >> 1) & 1);
    cpha = 1'(m & 1);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (cpha) begin
        sck[m] = ~cpol;
        mosi[m] = mo[i];
        tick(H);
        mi[i] = miso[m];
        sck[m] = cpol;
        tick(H);
      end else begin
        mosi[m] = mo[i];
        tick(H);
        mi[i] = miso[m];
        sck[m] = ~cpol;
        tick(H);
        sck[m] = cpol;
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [7:0] mi;
    logic [7:0] got [3];
    int rx0, und0;
    vec_t v;
    for (int i = 0; i < 4; i++) tx_data[i] = '0;
    vecs[0] = '{0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1, 1'b1, 8'h7E, 8'h81, 8'h81, 8'h7E, 0};
    vecs[2] = '{2, 1'b1, 8'h7E, 8'h81, 8'h81, 8'h7E, 0};
    vecs[3] = '{3, 1'b1, 8'h7E, 8'h81, 8'h81, 8'h7E, 0};
    vecs[4] = '{1, 1'b0, 8'h00, 8'h5A, 8'h5A, 8'hFF, 1};
    do_reset;
    check("reset ctl {ready,underrun,rx_valid,miso,miso_en}",
          {27'b0, tx_ready[0], underrun[0], rx_valid[0], miso[0], miso_en[0]}, 32'b10000);
    check("reset rx_data", rx_data[0], 0);
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      do_reset;
      rx0 = rx_cnt[v.mode];
      und0 = und_cnt[v.mode];
      if (v.has_tx) load_tx(v.mode, v.tx);
      cs_low(v.mode);
      check($sformatf("v%0d miso_en selected", k), miso_en[v.mode], 1);
      if (v.has_tx) load_tx(v.mode, 8'h00);
      xfer(v.mode, v.mo, 8, mi);
      cs_high(v.mode);
      check($sformatf("v%0d rx_valid count", k), rx_cnt[v.mode] - rx0, 1);
      check($sformatf("v%0d rx_data", k), rx_hist[v.mode][rx0 % 64], v.exp_rx);
      check($sformatf("v%0d miso word", k), mi, v.exp_miso);
      check($sformatf("v%0d underrun count", k), und_cnt[v.mode] - und0, v.exp_und);
      check($sformatf("v%0d miso_en idle", k), miso_en[v.mode], 0);
    end
    // three words under one CS, holding register refilled whenever it empties
    do_reset;
    rx0 = rx_cnt[0];
    und0 = und_cnt[0];
    load_tx(0, 8'h10);
    cs_low(0);
    fork
      begin
        logic [7:0] r;
        for (int w = 0; w < 3; w++) begin
          xfer(0, 8'(w + 1), 8, r);
          got[w] = r;
        end
      end
      begin
        load_tx(0, 8'h20);
        load_tx(0, 8'h30);
        load_tx(0, 8'h40);
      end
    join
    cs_high(0);
    check("b2b rx_valid count", rx_cnt[0] - rx0, 3);
    for (int w = 0; w < 3; w++) begin
      check($sformatf("b2b rx word %0d", w), rx_hist[0][(rx0 + w) % 64], w + 1);
      check($sformatf("b2b miso word %0d", w), got[w], (w + 1) * 16);
    end
    check("b2b underrun count", und_cnt[0] - und0, 0);
    // CS released after 5 bits, then a full word
    do_reset;
    rx0 = rx_cnt[0];
    cs_low(0);
    xfer(0, 8'hFF, 5, mi);
    cs_high(0);
    check("partial no rx_valid", rx_cnt[0] - rx0, 0);
    cs_low(0);
    xfer(0, 8'hC3, 8, mi);
    cs_high(0);
    check("after partial rx_valid count", rx_cnt[0] - rx0, 1);
    check("after partial rx_data", rx_hist[0][rx0 % 64], 8'hC3);
    check("after partial miso default", mi, 8'hFF);
    // reset in the middle of a word
    do_reset;
    cs_low(0);
    xfer(0, 8'h3C, 8, mi);
    cs_high(0);
    load_tx(0, 8'hFF);
    cs_low(0);
    xfer(0, 8'h3C, 4, mi);
    load_tx(0, 8'h42);
    check("midword pre-reset {ready,miso,miso_en}", {29'b0, tx_ready[0], miso[0], miso_en[0]}, 32'b011);
    rst_n = 1'b0;
    cs_n[0] = 1'b1;
    tick(1);
    check("midword reset ctl {ready,underrun,rx_valid,miso,miso_en}",
          {27'b0, tx_ready[0], underrun[0], rx_valid[0], miso[0], miso_en[0]}, 32'b10000);
    check("midword reset rx_data", rx_data[0], 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    rx0 = rx_cnt[0];
    load_tx(0, 8'h5A);
    cs_low(0);
    load_tx(0, 8'h00);
    xfer(0, 8'h96, 8, mi);
    cs_high(0);
    check("post-reset rx_valid count", rx_cnt[0] - rx0, 1);
    check("post-reset rx_data", rx_hist[0][rx0 % 64], 8'h96);
    check("post-reset miso word", mi, 8'h5A);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
